// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the five-stage pipeline with a one-entry fetch hold
// Inputs : clk, rst (async, active-high), stall_EX (load-use), br_taken_EX (EX redirect),
//          imem_resp, dmem_access_MEM, dmem_resp (cache handshakes)
// Outputs: imem_read, load_pc/load_IF_ID/load_ID_EX/load_EX_MEM/load_MEM_WB, bubble_EX_MEM,
//          flush_IF_ID/flush_ID_EX, load_fetch_buf, fetch_buf_sel
// Optional PIPE_PERF_CNT_EN: adds CNT_W-wide wrapping counters cnt_lu_stall, cnt_mem_stall, cnt_flush
module pipeline_hazard_controller
`ifdef PIPE_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic stall_EX,
    input  logic br_taken_EX,
    input  logic imem_resp,
    input  logic dmem_access_MEM,
    input  logic dmem_resp,
    output logic imem_read,
    output logic load_pc,
    output logic load_IF_ID,
    output logic load_ID_EX,
    output logic load_EX_MEM,
    output logic load_MEM_WB,
    output logic bubble_EX_MEM,
    output logic flush_IF_ID,
    output logic flush_ID_EX,
    output logic load_fetch_buf,
    output logic fetch_buf_sel
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_lu_stall,
    output logic [CNT_W-1:0] cnt_mem_stall,
    output logic [CNT_W-1:0] cnt_flush
`endif
);
    typedef enum logic [1:0] {I_IDLE, I_FETCH, I_HELD} istate_t;

    istate_t state, state_n;
    logic    fetch_ready, dmem_ready, freeze, front_go;

    assign fetch_ready = (state == I_FETCH && imem_resp) || state == I_HELD;
    assign dmem_ready  = !dmem_access_MEM || dmem_resp;
    assign freeze      = !fetch_ready || !dmem_ready;
    // Front end (PC, IF/ID, ID/EX) advances only when neither frozen nor load-use stalled;
    // a stalled redirect is dropped because its EX operand is stale.
    assign front_go    = !freeze && !stall_EX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= I_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n        = I_IDLE;
        imem_read      = state == I_FETCH;
        fetch_buf_sel  = state == I_HELD;
        load_fetch_buf = state == I_FETCH && imem_resp && !front_go;
        load_pc        = front_go;
        load_IF_ID     = front_go;
        load_ID_EX     = front_go;
        load_EX_MEM    = !freeze;
        load_MEM_WB    = !freeze;
        bubble_EX_MEM  = !freeze && stall_EX;
        flush_IF_ID    = front_go && br_taken_EX;
        flush_ID_EX    = front_go && br_taken_EX;
        state_n        = state == I_IDLE  ? I_FETCH :
                         state == I_FETCH ? ((imem_resp && !front_go) ? I_HELD : I_FETCH) :
                         state == I_HELD  ? (front_go ? I_FETCH : I_HELD) : I_IDLE;
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_lu_stall  <= '0;
            cnt_mem_stall <= '0;
            cnt_flush     <= '0;
        end else begin
            cnt_lu_stall  <= cnt_lu_stall  + CNT_W'(!freeze && stall_EX);
            cnt_mem_stall <= cnt_mem_stall + CNT_W'(freeze && state != I_IDLE);
            cnt_flush     <= cnt_flush     + CNT_W'(flush_IF_ID);
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed scenarios plus randomized run against a behavioural model
module tb_pipeline_hazard_controller;
    logic clk = 0, rst = 1;
    logic stall_EX = 0, br_taken_EX = 0, imem_resp = 0, dmem_access_MEM = 0, dmem_resp = 0;
    logic imem_read, load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB;
    logic bubble_EX_MEM, flush_IF_ID, flush_ID_EX, load_fetch_buf, fetch_buf_sel;
    logic [10:0] outs;
    int errors = 0, checks = 0;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] cnt_lu_stall, cnt_mem_stall, cnt_flush;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_controller dut (
        .clk(clk), .rst(rst), .stall_EX(stall_EX), .br_taken_EX(br_taken_EX),
        .imem_resp(imem_resp), .dmem_access_MEM(dmem_access_MEM), .dmem_resp(dmem_resp),
        .imem_read(imem_read), .load_pc(load_pc), .load_IF_ID(load_IF_ID), .load_ID_EX(load_ID_EX),
        .load_EX_MEM(load_EX_MEM), .load_MEM_WB(load_MEM_WB), .bubble_EX_MEM(bubble_EX_MEM),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .load_fetch_buf(load_fetch_buf),
        .fetch_buf_sel(fetch_buf_sel)
`ifdef PIPE_PERF_CNT_EN
        , .cnt_lu_stall(cnt_lu_stall), .cnt_mem_stall(cnt_mem_stall), .cnt_flush(cnt_flush)
`endif
    );

    // {imem_read, pc, IF_ID, ID_EX, EX_MEM, MEM_WB, bubble, flush_IF_ID, flush_ID_EX, load_fetch_buf, fetch_buf_sel}
    assign outs = {imem_read, load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
                   bubble_EX_MEM, flush_IF_ID, flush_ID_EX, load_fetch_buf, fetch_buf_sel};

    // Advance one clock, apply inputs just after the edge, settle to the falling edge for sampling.
    task automatic set_in(input logic s, input logic b, input logic ir, input logic da, input logic dr);
        @(posedge clk); #1;
        stall_EX = s; br_taken_EX = b; imem_resp = ir; dmem_access_MEM = da; dmem_resp = dr;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1; imem_resp = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (outs !== 11'b0) begin errors++; $display("FAIL reset_held got=%b exp=%b", outs, 11'b0); end
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checks++; if (outs !== 11'b0) begin errors++; $display("FAIL reset_cycle1 got=%b exp=%b", outs, 11'b0); end
`ifdef PIPE_PERF_CNT_EN
        checks++; if ({cnt_lu_stall, cnt_mem_stall, cnt_flush} !== 96'b0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", {cnt_lu_stall, cnt_mem_stall, cnt_flush}); end
`endif
        set_in(0, 0, 1, 0, 0);
        checks++; if (outs !== 11'b11111100000) begin errors++; $display("FAIL reset_cycle2 got=%b exp=%b", outs, 11'b11111100000); end
    endtask

    task automatic test_load_use;
        set_in(1, 0, 1, 0, 0);
        checks++; if (outs !== 11'b10001110010) begin errors++; $display("FAIL lu_stall got=%b exp=%b", outs, 11'b10001110010); end
        set_in(0, 0, 1, 0, 0);
        checks++; if (outs !== 11'b01111100001) begin errors++; $display("FAIL lu_release got=%b exp=%b", outs, 11'b01111100001); end
        set_in(0, 0, 1, 0, 0);
        checks++; if (outs !== 11'b11111100000) begin errors++; $display("FAIL lu_after got=%b exp=%b", outs, 11'b11111100000); end
    endtask

    task automatic test_redirect;
        set_in(0, 1, 1, 0, 0);
        checks++; if (outs !== 11'b11111101100) begin errors++; $display("FAIL br_flush got=%b exp=%b", outs, 11'b11111101100); end
        set_in(0, 0, 1, 0, 0);
        checks++; if (outs !== 11'b11111100000) begin errors++; $display("FAIL br_after got=%b exp=%b", outs, 11'b11111100000); end
        set_in(1, 1, 1, 0, 0);
        checks++; if (outs !== 11'b10001110010) begin errors++; $display("FAIL br_with_stall got=%b exp=%b", outs, 11'b10001110010); end
        set_in(0, 0, 1, 0, 0);
        checks++; if (outs !== 11'b01111100001) begin errors++; $display("FAIL br_stall_release got=%b exp=%b", outs, 11'b01111100001); end
        set_in(0, 0, 1, 0, 0);
    endtask

    task automatic test_mem_stall_hold;
        logic [31:0] base = 0;
`ifdef PIPE_PERF_CNT_EN
        base = cnt_mem_stall;
`endif
        set_in(0, 0, 1, 1, 0);
        checks++; if (outs !== 11'b10000000010) begin errors++; $display("FAIL ms_capture got=%b exp=%b", outs, 11'b10000000010); end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 1, 0);
            checks++; if (outs !== 11'b00000000001) begin errors++; $display("FAIL ms_held%0d got=%b exp=%b", i, outs, 11'b00000000001); end
        end
        set_in(0, 0, 0, 1, 1);
        checks++; if (outs !== 11'b01111100001) begin errors++; $display("FAIL ms_release got=%b exp=%b", outs, 11'b01111100001); end
`ifdef PIPE_PERF_CNT_EN
        checks++; if (cnt_mem_stall - base !== 32'd4) begin errors++; $display("FAIL ms_cnt got=%0d exp=4", cnt_mem_stall - base); end
`endif
        set_in(0, 0, 1, 0, 0);
        checks++; if (outs !== 11'b11111100000) begin errors++; $display("FAIL ms_after got=%b exp=%b", outs, 11'b11111100000); end
    endtask

    task automatic test_held_redirect;
        set_in(0, 0, 1, 1, 0);
        set_in(0, 0, 0, 1, 0);
        checks++; if (outs !== 11'b00000000001) begin errors++; $display("FAIL hr_held got=%b exp=%b", outs, 11'b00000000001); end
        set_in(0, 1, 0, 1, 1);
        checks++; if (outs !== 11'b01111101101) begin errors++; $display("FAIL hr_flush got=%b exp=%b", outs, 11'b01111101101); end
        set_in(0, 0, 0, 0, 0);
        checks++; if (outs !== 11'b10000000000) begin errors++; $display("FAIL hr_refetch got=%b exp=%b", outs, 11'b10000000000); end
        set_in(0, 0, 1, 0, 0);
    endtask

    task automatic test_reset_mid_stall;
        set_in(0, 0, 1, 1, 0);
        set_in(0, 0, 0, 1, 0);
        @(posedge clk); #1 rst = 1;
        #1;
        checks++; if (outs !== 11'b0) begin errors++; $display("FAIL rm_async got=%b exp=%b", outs, 11'b0); end
`ifdef PIPE_PERF_CNT_EN
        checks++; if ({cnt_lu_stall, cnt_mem_stall, cnt_flush} !== 96'b0) begin errors++; $display("FAIL rm_cnt got=%h exp=0", {cnt_lu_stall, cnt_mem_stall, cnt_flush}); end
`endif
        @(posedge clk); #1;
        rst = 0; imem_resp = 1; dmem_access_MEM = 0;
        @(negedge clk);
        checks++; if (outs !== 11'b0) begin errors++; $display("FAIL rm_idle got=%b exp=%b", outs, 11'b0); end
        set_in(0, 0, 1, 0, 0);
        checks++; if (outs !== 11'b11111100000) begin errors++; $display("FAIL rm_fetch got=%b exp=%b", outs, 11'b11111100000); end
    endtask

    // Model: 'started' is false only for the single idle cycle after reset; 'held' means a fetched
    // word is parked and the I-cache is not being read.
    task automatic test_random;
        bit started = 0, held = 0, frz, front, back;
        int n_lu = 0, n_mem = 0, n_fl = 0;
        logic [10:0] exp;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 400; i++) begin
            stall_EX = $urandom_range(3) == 0;
            br_taken_EX = $urandom_range(3) == 0;
            imem_resp = $urandom_range(1) == 1;
            dmem_access_MEM = $urandom_range(1) == 1;
            dmem_resp = $urandom_range(2) != 0;
            @(negedge clk);
            frz = !(started && (held || imem_resp)) || (dmem_access_MEM && !dmem_resp);
            back = !frz;
            front = back && !stall_EX;
            exp = {started && !held, front, front, front, back, back, back && stall_EX,
                   front && br_taken_EX, front && br_taken_EX,
                   started && !held && imem_resp && !front, held};
            checks++; if (outs !== exp) begin errors++; $display("FAIL rand%0d got=%b exp=%b", i, outs, exp); end
            n_lu += int'(back && stall_EX);
            n_mem += int'(frz && started);
            n_fl += int'(front && br_taken_EX);
            if (!started) started = 1;
            else if (held) held = !front;
            else held = imem_resp && !front;
            @(posedge clk); #1;
        end
`ifdef PIPE_PERF_CNT_EN
        checks++; if (cnt_lu_stall !== 32'(n_lu)) begin errors++; $display("FAIL rand_cnt_lu got=%0d exp=%0d", cnt_lu_stall, n_lu); end
        checks++; if (cnt_mem_stall !== 32'(n_mem)) begin errors++; $display("FAIL rand_cnt_mem got=%0d exp=%0d", cnt_mem_stall, n_mem); end
        checks++; if (cnt_flush !== 32'(n_fl)) begin errors++; $display("FAIL rand_cnt_flush got=%0d exp=%0d", cnt_flush, n_fl); end
`endif
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_redirect;
        test_mem_stall_hold;
        test_held_redirect;
        test_reset_mid_stall;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall and flush sequencer for the five-stage rv32i pipeline. It consumes the load-use stall request (`stall_EX`) raised by the data forwarding unit, together with I-cache and D-cache response handshakes and the EX-stage branch redirect. From these it drives every pipeline register load enable, the EX/MEM bubble, and the IF/ID and ID/EX flushes. It also owns a fetch FSM with a one-entry fetch hold, so a completed I-cache response is never lost while the pipeline is frozen.

## Interface
Parameters:
- `CNT_W`, 32, width of performance counters (only used with `PIPE_PERF_CNT_EN`)

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  reset, asynchronous, active-high
- `stall_EX`  in  1  load-use hazard: load in MEM, consumer in EX
- `br_taken_EX`  in  1  EX stage resolved a redirect (PC must change)
- `imem_resp`  in  1  I-cache read complete this cycle
- `dmem_access_MEM`  in  1  MEM-stage instruction is a load or store
- `dmem_resp`  in  1  D-cache access complete this cycle
- `imem_read`  out  1  I-cache read request
- `load_pc`, `load_IF_ID`, `load_ID_EX`, `load_EX_MEM`, `load_MEM_WB`  out  1 each  register load enables
- `bubble_EX_MEM`  out  1  load a NOP control word into EX/MEM
- `flush_IF_ID`, `flush_ID_EX`  out  1 each  replace the stage contents with a NOP
- `load_fetch_buf`  out  1  capture the I-cache rdata into the fetch hold register
- `fetch_buf_sel`  out  1  IF/ID instruction source: 1 = hold register, 0 = I-cache rdata
- `cnt_lu_stall`, `cnt_mem_stall`, `cnt_flush`  out  CNT_W each  performance counters (macro only)

## Operation
- Fetch FSM states:
  - I_IDLE (reset) → I_FETCH, unconditionally, on the next cycle.
  - I_FETCH: `imem_read`=1.
    - `imem_resp` & `load_IF_ID` → I_FETCH.
    - `imem_resp` & ~`load_IF_ID` → I_HELD, with `load_fetch_buf`=1.
    - Otherwise stay in I_FETCH.
  - I_HELD: `imem_read`=0 and `fetch_buf_sel`=1.
    - `load_IF_ID` → I_FETCH.
    - Otherwise stay in I_HELD.
- Ready and freeze terms:
  - `fetch_ready` = (I_FETCH & `imem_resp`) | I_HELD.
  - `dmem_ready` = ~`dmem_access_MEM` | `dmem_resp`.
  - `freeze` = ~`fetch_ready` | ~`dmem_ready`.
- Output priority, combinational from state and inputs:
  1. `freeze`: all `load_*`=0; bubble and flushes=0.
  2. `stall_EX`:
     - `load_MEM_WB`=1, `load_EX_MEM`=1, `bubble_EX_MEM`=1.
     - `load_pc`, `load_IF_ID`, `load_ID_EX`=0.
     - `br_taken_EX` is ignored, because the EX operand is stale.
  3. Otherwise: all `load_*`=1. If `br_taken_EX`, then `flush_IF_ID`=1 and `flush_ID_EX`=1.
- A redirect while in I_HELD takes the normal path: the held wrong-path word is flushed, and the FSM returns to I_FETCH at the new PC.
- `bubble_EX_MEM` and the flushes are only asserted when their register's load enable is also 1.

## Timing
- Outputs are combinational. Only the FSM state and the counters are registered.
- While `rst` is high, and in the first cycle after reset:
  - FSM is in I_IDLE; `imem_read`=0.
  - All `load_*`=0, because `fetch_ready`=0.
  - Bubble, flushes, `load_fetch_buf` and `fetch_buf_sel` are 0.
  - Counters are 0.
- First `imem_read` is asserted in the 2nd cycle after `rst` deasserts.
- A load-use stall costs exactly 1 cycle when no memory stall overlaps it.
- A redirect costs 2 flushed instructions. The new PC is loaded in the redirect cycle.
- If an I-cache response arrives during a D-cache stall, the instruction is held. It is consumed on the first non-frozen cycle with zero extra I-cache latency.
- Simultaneous `imem_resp` and `stall_EX`: the FSM goes to I_HELD, because `load_IF_ID`=0.
- Reset asserted mid-stall: state returns to I_IDLE immediately (async). The hold register contents are discarded.

## Configuration
- `PIPE_PERF_CNT_EN` defined: three CNT_W counters are built, wrapping on overflow.
  - `cnt_lu_stall` increments on cycles with ~`freeze` & `stall_EX`.
  - `cnt_mem_stall` increments on `freeze` cycles, excluding I_IDLE.
  - `cnt_flush` increments on `flush_IF_ID` cycles.
- `PIPE_PERF_CNT_EN` undefined: counter ports and logic are absent, and control behaviour is identical.

## Test plan
- Reset release with `imem_resp` tied 1:
  - Cycle 1: `imem_read`=0, all loads 0.
  - Cycle 2: `imem_read`=1, all loads 1.
- `stall_EX`=1 for 1 cycle, caches hitting: in that cycle `load_pc`/`load_IF_ID`/`load_ID_EX`=0, `load_EX_MEM`=`bubble_EX_MEM`=`load_MEM_WB`=1. The next cycle all loads are 1. `cnt_lu_stall`=1.
- `br_taken_EX`=1 with no stall: `flush_IF_ID`=`flush_ID_EX`=1 and all loads 1 for exactly 1 cycle. `br_taken_EX`=1 together with `stall_EX`=1: no flush.
- `dmem_access_MEM`=1, `dmem_resp` low for 4 cycles, `imem_resp`=1 in the first of those cycles:
  - `load_fetch_buf` pulses once; FSM goes to I_HELD with `imem_read`=0.
  - Loads stay 0 for 4 cycles, then all loads are 1 with `fetch_buf_sel`=1.
  - `cnt_mem_stall`=4.
- I_HELD plus `br_taken_EX` on release: flushes asserted, FSM goes to I_FETCH, `imem_read`=1 on the next cycle.
- `rst` pulsed while in I_HELD mid-D-cache stall: immediate I_IDLE, all outputs 0, counters 0.
